// File: rtl/glip_out_arbiter_if.sv
// Stream bundle between N packet requesters and one outgoing GLIP fifo_out channel.
// master = arbiter view, slave = requester/sink environment view.
`default_nettype none

interface glip_out_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/glip_out_arbiter.sv
// glip_out_arbiter: round-robin, packet-locked arbiter feeding GLIP fifo_out;
// every packet is prefixed by a header word carrying the source index.
`default_nettype none

module glip_out_arbiter #(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  localparam int IDW   = $clog2(N)
) (
  input  wire logic            clk_logic,
  input  wire logic            rst,
  glip_out_arbiter_if.master   bus,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic [IDW-1:0]   grant_inc;
  logic [WIDTH-1:0] words [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign words[g] = bus.in_data[g*WIDTH +: WIDTH];
  end

  // Scan from the highest offset down so the lowest offset at or after rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % N);
      if (bus.in_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign grant_inc = (grant_q == IDW'(N - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk_logic or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (bus.out_ready) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.in_valid[grant_q] && bus.out_ready && bus.in_last[grant_q]) begin
          rr_ptr_d = grant_inc;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Payload is a pure mux from the granted requester: no buffering, no added latency.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.in_ready  = '0;
    case (state_q)
      S_HDR: begin
        bus.out_valid          = 1'b1;
        bus.out_data[IDW-1:0]  = grant_q;
      end
      S_DATA: begin
        bus.out_valid          = bus.in_valid[grant_q];
        bus.out_data           = words[grant_q];
        bus.in_ready[grant_q]  = bus.out_ready & bus.in_valid[grant_q];
      end
      default: ;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_glip_out_arbiter.sv
// Scoreboard bench for glip_out_arbiter: queued requester drivers, expected-word queue
// and a monitor that checks every accepted output word.
`default_nettype none

module tb_glip_out_arbiter;
  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int IDW   = 2;

  logic           clk_logic = 1'b0;
  logic           rst;
  logic [IDW-1:0] grant_id;
  logic           busy;

  glip_out_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

  glip_out_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk_logic (clk_logic),
    .rst       (rst),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk_logic = ~clk_logic;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] sb [$];
  logic [WIDTH:0]   rq [N][$];
  logic [N-1:0]     stl = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input int src, input logic [WIDTH-1:0] base, input int n);
    logic [WIDTH:0] e;
    for (int k = 0; k < n; k++) begin
      e = {(k == n - 1) ? 1'b1 : 1'b0, base + WIDTH'(k)};
      rq[src].push_back(e);
    end
  endtask

  task automatic expect_pkt(input logic [WIDTH-1:0] hdr, input logic [WIDTH-1:0] base, input int n);
    sb.push_back(hdr);
    for (int k = 0; k < n; k++) sb.push_back(base + WIDTH'(k));
  endtask

  function automatic bit all_empty();
    bit r;
    r = (sb.size() == 0);
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (c < budget && !all_empty()) begin
      @(negedge clk_logic); #1;
      c++;
    end
    chk("drain_done", {31'd0, all_empty()}, 32'd1);
    repeat (2) @(negedge clk_logic);
  endtask

  task automatic wait_hdr(input string nm, input int budget);
    int c;
    c = 0;
    @(negedge clk_logic);
    while (c < budget && !(bus.out_valid && busy)) begin
      @(negedge clk_logic);
      c++;
    end
    chk(nm, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk_logic); #2;
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    stl = '0;
    repeat (2) @(negedge clk_logic);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {28'd0, bus.in_ready}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_grant_id",  {30'd0, grant_id}, 32'd0);
    @(posedge clk_logic); #2;
    rst = 1'b0;
  endtask

  // Requester drivers: retire words accepted at the last edge, then present queue heads.
  initial begin : drv
    logic [N-1:0]   acc;
    logic [WIDTH:0] e;
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk_logic);
      acc = bus.in_valid & bus.in_ready;
      @(posedge clk_logic); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0 && !stl[i]) begin
          e = rq[i][0];
          bus.in_valid[i] = 1'b1;
          bus.in_last[i]  = e[WIDTH];
          bus.in_data[i*WIDTH +: WIDTH] = e[WIDTH-1:0];
        end else begin
          bus.in_valid[i] = 1'b0;
          bus.in_last[i]  = 1'b0;
        end
      end
    end
  end

  initial begin : mon
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk_logic);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_word: got 0x%0h expected no word at %0t", bus.out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("out_word", {16'd0, bus.out_data}, {16'd0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int c;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();

    // 1: three-word packet from req1, header one cycle after valid rises
    @(negedge clk_logic);
    send(1, 16'hA000, 3);
    expect_pkt(16'h0001, 16'hA000, 3);
    @(negedge clk_logic);
    chk("t1_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_idle_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk_logic);
    chk("t1_hdr_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_hdr_data",  {16'd0, bus.out_data}, 32'h0001);
    chk("t1_hdr_busy",  {31'd0, busy}, 32'd1);
    chk("t1_hdr_inrdy", {28'd0, bus.in_ready}, 32'd0);
    drain(40);
    chk("t1_end_busy",  {31'd0, busy}, 32'd0);
    chk("t1_grant_hold", {30'd0, grant_id}, 32'd1);

    // 2: simultaneous single-word packets from reset, then pointer wrap
    do_reset();
    @(negedge clk_logic);
    send(0, 16'hB000, 1);
    send(2, 16'hB200, 1);
    send(3, 16'hB300, 1);
    expect_pkt(16'h0000, 16'hB000, 1);
    expect_pkt(16'h0002, 16'hB200, 1);
    expect_pkt(16'h0003, 16'hB300, 1);
    drain(60);
    @(negedge clk_logic);
    send(2, 16'hB210, 1);
    send(0, 16'hB010, 1);
    expect_pkt(16'h0000, 16'hB010, 1);
    expect_pkt(16'h0002, 16'hB210, 1);
    drain(60);

    // 3: backpressure in HDR and mid-DATA
    @(posedge clk_logic); #1;
    bus.out_ready = 1'b0;
    @(negedge clk_logic);
    send(3, 16'hC300, 4);
    expect_pkt(16'h0003, 16'hC300, 4);
    wait_hdr("t3_hdr_seen", 20);
    for (int k = 0; k < 4; k++) begin
      chk("t3_hdr_hold_data", {16'd0, bus.out_data}, 32'h0003);
      chk("t3_hdr_hold_inrdy", {28'd0, bus.in_ready}, 32'd0);
      @(negedge clk_logic);
    end
    @(posedge clk_logic); #1;
    bus.out_ready = 1'b1;
    @(posedge clk_logic);
    @(posedge clk_logic); #1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_logic);
      chk("t3_data_hold", {16'd0, bus.out_data}, 32'hC301);
      chk("t3_data_inrdy", {28'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk_logic); #1;
    bus.out_ready = 1'b1;
    drain(40);

    // 4: grant locked on req0 while req1 requests
    @(negedge clk_logic);
    send(0, 16'hD000, 3);
    expect_pkt(16'h0000, 16'hD000, 3);
    expect_pkt(16'h0001, 16'hD100, 1);
    wait_hdr("t4_hdr_seen", 20);
    send(1, 16'hD100, 1);
    repeat (2) begin
      @(negedge clk_logic);
      chk("t4_lock_grant", {30'd0, grant_id}, 32'd0);
      chk("t4_lock_inrdy1", {31'd0, bus.in_ready[1]}, 32'd0);
    end
    drain(40);

    // 5: asynchronous reset mid-DATA, then arbitration restarts from index 0
    @(negedge clk_logic);
    send(3, 16'hE300, 4);
    expect_pkt(16'h0003, 16'hE300, 2);
    for (c = 0; c < 60; c++) begin
      @(posedge clk_logic); #2;
      if (sb.size() == 0) break;
    end
    chk("t5_pre_rst", sb.size(), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t5_rst_inrdy", {28'd0, bus.in_ready}, 32'd0);
    chk("t5_rst_busy",  {31'd0, busy}, 32'd0);
    chk("t5_rst_grant", {30'd0, grant_id}, 32'd0);
    for (int i = 0; i < N; i++) rq[i].delete();
    #18;
    rst = 1'b0;
    @(negedge clk_logic);
    send(1, 16'hE100, 1);
    send(3, 16'hE310, 1);
    expect_pkt(16'h0001, 16'hE100, 1);
    expect_pkt(16'h0003, 16'hE310, 1);
    drain(60);

    // 6: granted requester stalls for two cycles mid-packet
    @(negedge clk_logic);
    send(2, 16'hF200, 5);
    expect_pkt(16'h0002, 16'hF200, 5);
    wait_hdr("t6_hdr_seen", 20);
    @(negedge clk_logic);
    stl[2] = 1'b1;
    repeat (2) begin
      @(negedge clk_logic);
      chk("t6_stall_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t6_stall_grant", {30'd0, grant_id}, 32'd2);
      chk("t6_stall_busy",  {31'd0, busy}, 32'd1);
    end
    stl[2] = 1'b0;
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
